// File: rtl/iob_clint_pkg.sv
// Shared CLINT map and FSM encodings for the CLINT timer scheduler and its write sequencer.
package iob_clint_pkg;

   localparam logic [15:0] MSIP_BASE     = 16'h0000;
   localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
   localparam logic [15:0] MTIME_BASE    = 16'hBFF8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_WRITE,
      S_SETTLE,
      S_ARMED,
      S_FIRE
   } sched_state_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_REQ,
      W_GAP
   } wr_state_e;

endpackage

// File: rtl/iob_clint_wr_seq.sv
// Three-write iob master: lo=all-ones, hi=tgt[63:32], lo=tgt[31:0], with a one-cycle
// valid gap between writes because the CLINT registers ready from valid.
module iob_clint_wr_seq
   import iob_clint_pkg::*;
#(
   parameter int unsigned       ADDR_W = 16,
   parameter int unsigned       DATA_W = 32,
   parameter logic [ADDR_W-1:0] BASE   = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [63:0]         tgt,
   input  logic                m_ready,
   output logic                m_valid,
   output logic [ADDR_W-1:0]   m_address,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   output logic                done_c
);

   wr_state_e             state_q, state_d;
   logic [1:0]            phase_q, phase_d;
   logic [63:0]           tgt_q, tgt_d;
   logic                  valid_q, valid_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= W_IDLE;
         phase_q <= '0;
         tgt_q   <= '0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         tgt_q   <= tgt_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
      end
   end

   // m_ready seen in W_GAP is the stale echo of the previous write and is ignored
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      tgt_d   = tgt_q;
      valid_d = valid_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      done_c  = 1'b0;
      case (state_q)
         W_IDLE: begin
            if (start) begin
               state_d = W_REQ;
               phase_d = 2'd0;
               tgt_d   = tgt;
               valid_d = 1'b1;
               addr_d  = BASE;
               wdata_d = '1;
            end
         end
         W_REQ: begin
            if (m_ready) begin
               valid_d = 1'b0;
               if (phase_q == 2'd2) begin
                  done_c  = 1'b1;
                  state_d = W_IDLE;
               end else begin
                  state_d = W_GAP;
                  phase_d = phase_q + 2'd1;
               end
            end
         end
         W_GAP: begin
            state_d = W_REQ;
            valid_d = 1'b1;
            if (phase_q == 2'd1) begin
               addr_d  = BASE + ADDR_W'(4);
               wdata_d = DATA_W'(tgt_q[63:32]);
            end else begin
               addr_d  = BASE;
               wdata_d = DATA_W'(tgt_q[31:0]);
            end
         end
         default: state_d = W_IDLE;
      endcase
      wstrb_d = valid_d ? '1 : '0;
   end

   assign m_valid   = valid_q;
   assign m_address = addr_q;
   assign m_wdata   = wdata_q;
   assign m_wstrb   = wstrb_q;

endmodule

// File: rtl/iob_clint_tmr_sched.sv
// Software-timer scheduler: keeps N_TIMERS deadlines, programs mtimecmp of HART_ID with
// the earliest armed one and retires it when mtip rises.
module iob_clint_tmr_sched
   import iob_clint_pkg::*;
#(
   parameter int unsigned  ADDR_W   = 16,
   parameter int unsigned  DATA_W   = 32,
   parameter int unsigned  N_TIMERS = 4,
   parameter int unsigned  HART_ID  = 0,
   parameter int unsigned  N_CORES  = 1,
   localparam int unsigned IDX_W    = $clog2(N_TIMERS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                set_valid,
   input  logic [IDX_W-1:0]    set_idx,
   input  logic [63:0]         set_deadline,
   input  logic                clr_valid,
   input  logic [IDX_W-1:0]    clr_idx,
   output logic                m_valid,
   output logic [ADDR_W-1:0]   m_address,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   input  logic                m_ready,
   input  logic [N_CORES-1:0]  mtip_i,
   output logic [N_TIMERS-1:0] fired,
   output logic [N_TIMERS-1:0] armed,
   output logic                busy
);

   localparam logic [ADDR_W-1:0] CMP_ADDR = ADDR_W'(MTIMECMP_BASE + 16'(8 * HART_ID));

   sched_state_e        state_q, state_d;
   logic [63:0]         dl_q [N_TIMERS];
   logic [63:0]         dl_d [N_TIMERS];
   logic [N_TIMERS-1:0] armed_q, armed_d, fired_q, fired_d;
   logic                dirty_q, dirty_d, busy_q, busy_d;
   logic [IDX_W-1:0]    cnt_q, cnt_d, sel_q, sel_d;
   logic [63:0]         best_q, best_d, tgt_c, scan_best_c;
   logic                found_q, found_d, scan_found_c, scan_take_c;
   logic                scan_last_c, req_c, wr_done_c;

   assign req_c       = set_valid | clr_valid;
   assign scan_last_c = (cnt_q == IDX_W'(N_TIMERS - 1));

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Pending requests outrank a fire so a just-cleared timer can never fire
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (dirty_q) state_d = S_SCAN;
         S_SCAN:   if (scan_last_c) state_d = S_WRITE;
         S_WRITE: begin
            if (wr_done_c) begin
               if (dirty_q)       state_d = S_SCAN;
               else if (!found_q) state_d = S_IDLE;
               else               state_d = S_SETTLE;
            end
         end
         S_SETTLE: state_d = S_ARMED;
         S_ARMED: begin
            if (dirty_q || req_c)       state_d = S_SCAN;
            else if (mtip_i[HART_ID])   state_d = S_FIRE;
         end
         S_FIRE:   state_d = S_SCAN;
         default:  state_d = S_IDLE;
      endcase
   end

   // Requests landing in the scan-entry cycle are in the RAM before entry 0 is read
   always_comb begin
      dl_d    = dl_q;
      armed_d = armed_q;
      fired_d = '0;
      cnt_d   = (state_q == S_SCAN && !scan_last_c) ? cnt_q + IDX_W'(1) : '0;
      dirty_d = dirty_q | req_c;
      if (state_d == S_SCAN && state_q != S_SCAN) dirty_d = 1'b0;
      if (state_d == S_FIRE) begin
         fired_d[sel_q] = 1'b1;
         armed_d[sel_q] = 1'b0;
      end
      if (clr_valid) armed_d[clr_idx] = 1'b0;
      if (set_valid) begin
         armed_d[set_idx] = 1'b1;
         dl_d[set_idx]    = set_deadline;
      end
      busy_d = (state_d != S_IDLE) && (state_d != S_ARMED);
   end

   // One entry per SCAN cycle; strict less-than keeps ties on the lowest index
   always_comb begin
      scan_found_c = (cnt_q == '0) ? 1'b0 : found_q;
      scan_best_c  = (cnt_q == '0) ? '1 : best_q;
      scan_take_c  = armed_q[cnt_q] && (!scan_found_c || (dl_q[cnt_q] < scan_best_c));
      best_d  = best_q;
      sel_d   = sel_q;
      found_d = found_q;
      if (state_q == S_SCAN) begin
         found_d = scan_found_c | scan_take_c;
         best_d  = scan_take_c ? dl_q[cnt_q] : scan_best_c;
         sel_d   = scan_take_c ? cnt_q : ((cnt_q == '0) ? '0 : sel_q);
      end
      tgt_c = found_d ? best_d : '1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         armed_q <= '0;
         fired_q <= '0;
         dirty_q <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         sel_q   <= '0;
         best_q  <= '1;
         found_q <= 1'b0;
      end else begin
         armed_q <= armed_d;
         fired_q <= fired_d;
         dirty_q <= dirty_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         best_q  <= best_d;
         found_q <= found_d;
      end
   end

   always_ff @(posedge clk) dl_q <= dl_d;

   iob_clint_wr_seq #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .BASE   (CMP_ADDR)
   ) u_wr_seq (
      .clk       (clk),
      .rst       (rst),
      .start     (state_q == S_SCAN && scan_last_c),
      .tgt       (tgt_c),
      .m_ready   (m_ready),
      .m_valid   (m_valid),
      .m_address (m_address),
      .m_wdata   (m_wdata),
      .m_wstrb   (m_wstrb),
      .done_c    (wr_done_c)
   );

   assign fired = fired_q;
   assign armed = armed_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_iob_clint_tmr_sched.sv
// Scoreboard bench for iob_clint_tmr_sched against a small CLINT model driven by a bench mtime.
module tb_iob_clint_tmr_sched;

   localparam int unsigned IDX_W = 2;
   localparam logic [63:0] ALL1  = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef struct packed {
      logic [15:0] a;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        set_valid, clr_valid;
   logic [1:0]  set_idx, clr_idx;
   logic [63:0] set_deadline;
   logic        m_valid, m_ready, busy;
   logic [15:0] m_address;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb, fired, armed;
   logic [0:0]  mtip;
   logic [63:0] mtime, mtimecmp;

   wr_t         wq[$];
   logic [3:0]  fq[$];
   int          wrd, frd, total, bad, tmo_cnt;
   logic        sb_off, rst_chk, arm_chk, end_chk, hs_prev;
   logic [3:0]  arm_exp;

   always #5 clk = ~clk;

   iob_clint_tmr_sched dut (
      .clk          (clk),
      .rst          (rst),
      .set_valid    (set_valid),
      .set_idx      (set_idx),
      .set_deadline (set_deadline),
      .clr_valid    (clr_valid),
      .clr_idx      (clr_idx),
      .m_valid      (m_valid),
      .m_address    (m_address),
      .m_wdata      (m_wdata),
      .m_wstrb      (m_wstrb),
      .m_ready      (m_ready),
      .mtip_i       (mtip),
      .fired        (fired),
      .armed        (armed),
      .busy         (busy)
   );

   // CLINT model: ready is valid delayed, mtip is a registered compare
   initial begin
      mtimecmp = ALL1;
      m_ready  = 1'b0;
      mtip     = 1'b0;
   end
   always @(posedge clk) begin
      m_ready <= m_valid;
      if (m_valid && m_address == 16'h4000) mtimecmp[31:0]  <= m_wdata;
      if (m_valid && m_address == 16'h4004) mtimecmp[63:32] <= m_wdata;
      mtip <= 1'(mtime >= mtimecmp);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   initial begin
      wrd = 0; frd = 0; total = 0; bad = 0; hs_prev = 1'b0;
   end

   // Monitor: all comparisons happen here, on the falling edge
   always @(negedge clk) begin
      if (rst_chk) begin
         chk("rst_m_valid", 64'(m_valid), 64'd0);
         chk("rst_m_wstrb", 64'(m_wstrb), 64'd0);
         chk("rst_armed",   64'(armed),   64'd0);
         chk("rst_fired",   64'(fired),   64'd0);
         chk("rst_busy",    64'(busy),    64'd0);
      end
      if (arm_chk) chk("armed", 64'(armed), 64'(arm_exp));
      if (m_valid) chk("wstrb", 64'(m_wstrb), 64'hF);
      if (hs_prev) chk("valid_gap", 64'(m_valid), 64'd0);
      hs_prev = m_valid && m_ready;
      if (m_valid && m_ready && !sb_off) begin
         if (wrd >= wq.size()) begin
            total++; bad++;
            $display("FAIL wr_extra addr=%h data=%h", m_address, m_wdata);
         end else begin
            chk("wr_addr", 64'(m_address), 64'(wq[wrd].a));
            chk("wr_data", 64'(m_wdata),   64'(wq[wrd].d));
            wrd++;
         end
      end
      if (fired != 4'd0) begin
         chk("fired_onehot0", 64'($onehot0(fired)), 64'd1);
         if (frd >= fq.size()) begin
            total++; bad++;
            $display("FAIL fired_extra act=%b", fired);
         end else begin
            chk("fired_vec", 64'(fired), 64'(fq[frd]));
            frd++;
         end
      end
      if (end_chk) begin
         chk("wr_pending",   64'(wrd),     64'(wq.size()));
         chk("fire_pending", 64'(frd),     64'(fq.size()));
         chk("timeouts",     64'(tmo_cnt), 64'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic do_set(input int idx, input logic [63:0] dl);
      set_valid = 1'b1; set_idx = IDX_W'(idx); set_deadline = dl;
      tick();
      set_valid = 1'b0;
   endtask

   task automatic do_clr(input int idx);
      clr_valid = 1'b1; clr_idx = IDX_W'(idx);
      tick();
      clr_valid = 1'b0;
   endtask

   task automatic exp_wr(input logic [63:0] t);
      wq.push_back({16'h4000, 32'hFFFF_FFFF});
      wq.push_back({16'h4004, t[63:32]});
      wq.push_back({16'h4000, t[31:0]});
   endtask

   task automatic exp_fire(input int idx);
      fq.push_back(4'(1 << idx));
   endtask

   task automatic check_armed(input logic [3:0] e);
      arm_exp = e; arm_chk = 1'b1;
      tick();
      arm_chk = 1'b0;
   endtask

   task automatic wait_wr1();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (m_valid && m_address == 16'h4004) seen = 1'b1;
      end
      if (!seen) tmo_cnt++;
   endtask

   initial begin
      rst = 1'b1; set_valid = 1'b0; clr_valid = 1'b0; set_idx = '0; clr_idx = '0;
      set_deadline = '0; mtime = '0; tmo_cnt = 0; sb_off = 1'b0;
      rst_chk = 1'b0; arm_chk = 1'b0; end_chk = 1'b0; arm_exp = '0;
      ticks(3);
      rst_chk = 1'b1; tick(); rst_chk = 1'b0;
      rst = 1'b0;
      tick();

      // 1: single timer, fire, reprogram all-ones
      exp_wr(64'd100);
      do_set(2, 64'd100);
      ticks(30);
      check_armed(4'b0100);
      exp_fire(2); exp_wr(ALL1);
      mtime = 64'd100;
      ticks(40);
      check_armed(4'b0000);

      // 2: back-to-back sets merge into one scan
      mtime = 64'd0;
      exp_wr(64'd300);
      do_set(0, 64'd500);
      do_set(1, 64'd300);
      ticks(30);
      check_armed(4'b0011);
      exp_fire(1); exp_wr(64'd500);
      mtime = 64'd300;
      ticks(40);
      check_armed(4'b0001);
      exp_fire(0); exp_wr(ALL1);
      mtime = 64'd500;
      ticks(40);

      // 3: equal deadlines in the past fire lowest index first, then the other
      exp_wr(64'd200); exp_fire(0);
      exp_wr(64'd200); exp_fire(3);
      exp_wr(ALL1);
      do_set(0, 64'd200);
      do_set(3, 64'd200);
      ticks(60);
      check_armed(4'b0000);

      // 4: clear an armed timer before it expires
      mtime = 64'd900;
      exp_wr(64'd1000);
      do_set(1, 64'd1000);
      ticks(30);
      check_armed(4'b0010);
      exp_wr(ALL1);
      do_clr(1);
      ticks(30);
      mtime = 64'd2000;
      ticks(30);
      check_armed(4'b0000);

      // 5: new earlier deadline while the write sequence is in flight
      mtime = 64'd10;
      exp_wr(64'd5000);
      exp_wr(64'd50);
      do_set(2, 64'd5000);
      wait_wr1();
      do_set(0, 64'd50);
      ticks(40);
      check_armed(4'b0101);

      // 6: reset in the middle of WR1
      sb_off = 1'b1;
      do_set(1, 64'd777);
      wait_wr1();
      rst = 1'b1;
      tick();
      rst_chk = 1'b1; tick(); rst_chk = 1'b0;
      rst = 1'b0; sb_off = 1'b0;
      tick();
      exp_wr(64'd60);
      do_set(3, 64'd60);
      ticks(30);
      check_armed(4'b1000);
      exp_fire(3); exp_wr(ALL1);
      mtime = 64'd60;
      ticks(40);
      check_armed(4'b0000);

      end_chk = 1'b1; tick(); end_chk = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
